piso_serializer_tx: RTL and testbench
=====================================

Name: piso_serializer_tx

Overview:
Parallel-in, serial-out transmitter with a ready/valid handshake on the parallel side and a framed serial stream on the output side. Words are accepted into a one-entry holding register while the previous word is being shifted out, so back-to-back frames need no idle cycles. Serial order is MSB-first by default. The block drives the team's serial shift-register chains and any bit-serial link that consumes sout/sout_valid.

Parameters:
WIDTH, 8, bits per frame (min 2)
GAP_CYCLES, 0, idle cycles with sout_valid=0 inserted after each frame (0..15)
MSB_FIRST, 1, 1 = shift out din[WIDTH-1] first; 0 = din[0] first

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  synchronous, active-high reset
din  input  WIDTH  parallel word to transmit
din_valid  input  1  din holds a valid word
din_ready  output  1  holding register empty; word accepted on an edge where din_valid && din_ready
sout  output  1  serial data bit, registered
sout_valid  output  1  sout carries a frame bit this cycle
sout_last  output  1  high with the final bit of each frame
busy  output  1  shifter in SHIFT or GAP, or holding register full
tx_count  output  16  frames fully transmitted, wraps 16'hFFFF -> 0

Behaviour:
- Reset (rst=1 at an edge): sout=0, sout_valid=0, sout_last=0, busy=0, tx_count=0, hold empty, state IDLE. din_ready is forced to 0 while rst=1 and is 1 in the first cycle after rst deasserts.
- din_ready = !hold_full && !rst. It is a function of registered state only, with no combinational path from din_valid.
- Accept: on an edge with din_valid && din_ready, din is captured into hold and hold_full is set. din and din_valid are ignored while din_ready=0.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: on an edge with hold_full, load the shifter from hold, clear hold_full, set bit_cnt=0, and go to SHIFT. The first bit is driven on sout with sout_valid=1 in the cycle after that edge.
  - SHIFT: one bit per cycle; bit_cnt increments each edge. The bit with bit_cnt==WIDTH-1 drives sout_last=1.
  - On the edge that ends the last bit, tx_count increments. Then:
    - If GAP_CYCLES>0, go to GAP.
    - Else, if hold_full, reload from hold and stay in SHIFT (seamless; the next frame's first bit follows immediately).
    - Else go to IDLE.
  - GAP: sout_valid=0, sout=0 for exactly GAP_CYCLES cycles, then the same reload-or-IDLE decision.
- Latency: word accepted at edge N while IDLE → first bit valid in the cycle after edge N+1. The frame occupies WIDTH consecutive cycles.
- Throughput: with GAP_CYCLES=0 and the producer keeping hold filled, sout_valid stays high continuously.
- Hold and shifter registers are separate. hold is freed on the reload edge, so din_ready rises in the following cycle, which leaves WIDTH-1 cycles to refill before the next reload.
- Idle outputs: sout=0 and sout_last=0 whenever sout_valid=0.
- busy = (state!=IDLE) || hold_full.
- Reset mid-frame: the partial frame is discarded, sout_valid=0 from the next cycle, the hold contents are lost, and tx_count is not incremented for the aborted frame.
- tx_count wraps silently with no saturation.

Test Plan:
- Single frame, WIDTH=8, MSB_FIRST=1: din=8'hB4 accepted at edge N → sout 1,0,1,1,0,1,0,0 on cycles N+2..N+9, sout_last only on the 8th bit, then sout_valid=0 and tx_count=1.
- Back-to-back, GAP_CYCLES=0: din_valid held with 8'hA5 then 8'h3C → 16 consecutive sout_valid cycles carrying 10100101 00111100, sout_last on bits 8 and 16, and din_ready low while hold is full.
- GAP_CYCLES=2: two frames 8'hFF, 8'h00 → exactly 2 cycles of sout_valid=0 between frames. MSB_FIRST=0 with 8'h01 → first bit 1, remaining bits 0.
- Backpressure: din_valid held high with changing din while din_ready=0 → only the words present on edges where din_ready=1 appear on sout, with none dropped or duplicated.
- Reset mid-frame: rst for 1 cycle after 3 bits of 8'hC3 with 8'h5A in hold → sout_valid=0 the next cycle, tx_count=0, din_ready=1 after reset, and no remnant bits from either word.
- Counter wrap: force or run 65536 frames → tx_count goes 16'hFFFF → 16'h0000 on the last-bit edge.

Source files
------------

// File: rtl/piso_serializer_tx_if.sv
// piso_serializer_tx_if: parallel handshake and framed serial stream bundle
interface piso_serializer_tx_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             sout;
   logic             sout_valid;
   logic             sout_last;
   logic             busy;
   logic [15:0]      tx_count;
   modport master (
      output din, din_valid,
      input  din_ready, sout, sout_valid, sout_last, busy, tx_count
   );
   modport slave (
      input  din, din_valid,
      output din_ready, sout, sout_valid, sout_last, busy, tx_count
   );
endinterface

// File: rtl/piso_serializer_tx.sv
// piso_serializer_tx: parallel-in serial-out transmitter with one-word hold register and framed output
module piso_serializer_tx #(
   parameter int WIDTH      = 8,
   parameter int GAP_CYCLES = 0,
   parameter bit MSB_FIRST  = 1
) (
   input logic                clk,
   input logic                rst,
   piso_serializer_tx_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] hold_q, hold_d, shreg_q, shreg_d;
   logic             hold_full_q, hold_full_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [3:0]       gap_cnt_q, gap_cnt_d;
   logic [15:0]      tx_count_q, tx_count_d;
   logic             sout_q, sout_d, sout_valid_q, sout_valid_d, sout_last_q, sout_last_d;
   logic             din_ready, load;
   assign din_ready      = !hold_full_q && !rst;
   assign bus.din_ready  = din_ready;
   assign bus.sout       = sout_q;
   assign bus.sout_valid = sout_valid_q;
   assign bus.sout_last  = sout_last_q;
   assign bus.busy       = (state_q != IDLE) || hold_full_q;
   assign bus.tx_count   = tx_count_q;
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shreg_d     = shreg_q;
      bit_cnt_d   = bit_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      tx_count_d  = tx_count_q;
      load        = 1'b0;
      if (bus.din_valid && din_ready) begin
         hold_d      = bus.din;
         hold_full_d = 1'b1;
      end
      case (state_q)
         IDLE: load = hold_full_q;
         SHIFT: begin
            if (bit_cnt_q == LAST) begin
               tx_count_d = tx_count_q + 16'd1;
               if (GAP_CYCLES > 0) begin
                  state_d   = GAP;
                  gap_cnt_d = 4'(GAP_CYCLES - 1);
               end else begin
                  load    = hold_full_q;
                  state_d = IDLE;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
               shreg_d   = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
            end
         end
         GAP: begin
            if (gap_cnt_q == 4'd0) begin
               load    = hold_full_q;
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      // hold and shifter are separate, so the reload frees hold for the next word
      if (load) begin
         state_d     = SHIFT;
         shreg_d     = hold_q;
         hold_full_d = 1'b0;
         bit_cnt_d   = '0;
      end
      sout_valid_d = state_d == SHIFT;
      sout_d       = sout_valid_d && (MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0]);
      sout_last_d  = sout_valid_d && (bit_cnt_d == LAST);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         hold_q       <= '0;
         hold_full_q  <= 1'b0;
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         gap_cnt_q    <= '0;
         tx_count_q   <= '0;
         sout_q       <= 1'b0;
         sout_valid_q <= 1'b0;
         sout_last_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         hold_full_q  <= hold_full_d;
         shreg_q      <= shreg_d;
         bit_cnt_q    <= bit_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         tx_count_q   <= tx_count_d;
         sout_q       <= sout_d;
         sout_valid_q <= sout_valid_d;
         sout_last_q  <= sout_last_d;
      end
   end
endmodule

// File: tb/tb_piso_serializer_tx.sv
// tb_piso_serializer_tx: directed-vector bench for three serializer configurations
module tb_piso_serializer_tx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   logic [7:0]  din_a [3];
   logic        dv_a  [3];
   logic        rdy   [3];
   logic        so    [3];
   logic        sv    [3];
   logic        sl    [3];
   logic        bz    [3];
   logic [15:0] tc    [3];
   always #5 clk = ~clk;
   piso_serializer_tx_if #(.WIDTH(8)) if0 ();
   piso_serializer_tx_if #(.WIDTH(8)) if1 ();
   piso_serializer_tx_if #(.WIDTH(8)) if2 ();
   piso_serializer_tx #(.WIDTH(8), .GAP_CYCLES(0), .MSB_FIRST(1)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
   piso_serializer_tx #(.WIDTH(8), .GAP_CYCLES(2), .MSB_FIRST(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
   piso_serializer_tx #(.WIDTH(8), .GAP_CYCLES(0), .MSB_FIRST(0)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
   assign if0.din = din_a[0];
   assign if1.din = din_a[1];
   assign if2.din = din_a[2];
   assign if0.din_valid = dv_a[0];
   assign if1.din_valid = dv_a[1];
   assign if2.din_valid = dv_a[2];
   assign rdy[0] = if0.din_ready;
   assign rdy[1] = if1.din_ready;
   assign rdy[2] = if2.din_ready;
   assign so[0] = if0.sout;
   assign so[1] = if1.sout;
   assign so[2] = if2.sout;
   assign sv[0] = if0.sout_valid;
   assign sv[1] = if1.sout_valid;
   assign sv[2] = if2.sout_valid;
   assign sl[0] = if0.sout_last;
   assign sl[1] = if1.sout_last;
   assign sl[2] = if2.sout_last;
   assign bz[0] = if0.busy;
   assign bz[1] = if1.busy;
   assign bz[2] = if2.busy;
   assign tc[0] = if0.tx_count;
   assign tc[1] = if1.tx_count;
   assign tc[2] = if2.tx_count;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input int k, input logic [7:0] w);
      logic r;
      dv_a[k] = 1'b1;
      do begin
         r = rdy[k];
         din_a[k] = r ? w : 8'($urandom);
         tick();
      end while (!r);
      dv_a[k] = 1'b0;
   endtask
   task automatic wait_valid(input int k);
      int t = 0;
      while (!sv[k] && t < 50) begin
         tick();
         t++;
      end
      chk("frame_start", {31'd0, sv[k]}, 32'd1);
   endtask
   task automatic chk_frame(input int k, input logic [7:0] w, input bit msb);
      for (int i = 0; i < 8; i++) begin
         chk("valid", {31'd0, sv[k]}, 32'd1);
         chk("bit", {31'd0, so[k]}, {31'd0, msb ? w[7-i] : w[i]});
         chk("last", {31'd0, sl[k]}, {31'd0, i == 7});
         tick();
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1);
   end
   initial begin
      logic quiet;
      for (int k = 0; k < 3; k++) begin
         din_a[k] = 8'h00;
         dv_a[k] = 1'b0;
      end
      tick();
      tick();
      chk("rst_valid", {31'd0, sv[0]}, 32'd0);
      chk("rst_busy", {31'd0, bz[0]}, 32'd0);
      chk("rst_count", {16'd0, tc[0]}, 32'd0);
      chk("rst_ready", {31'd0, rdy[0]}, 32'd0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", {31'd0, rdy[0]}, 32'd1);
      send(0, 8'hB4);
      chk("hold_full_ready", {31'd0, rdy[0]}, 32'd0);
      chk("hold_full_busy", {31'd0, bz[0]}, 32'd1);
      chk("latency_idle", {31'd0, sv[0]}, 32'd0);
      tick();
      chk_frame(0, 8'hB4, 1);
      chk("single_end", {31'd0, sv[0]}, 32'd0);
      chk("single_count", {16'd0, tc[0]}, 32'd1);
      fork
         begin
            send(0, 8'hA5);
            send(0, 8'h3C);
         end
         begin
            wait_valid(0);
            chk_frame(0, 8'hA5, 1);
            chk_frame(0, 8'h3C, 1);
         end
      join
      chk("b2b_end", {31'd0, sv[0]}, 32'd0);
      chk("b2b_count", {16'd0, tc[0]}, 32'd3);
      fork
         begin
            send(0, 8'h81);
            send(0, 8'h7E);
            send(0, 8'hD2);
         end
         begin
            wait_valid(0);
            chk_frame(0, 8'h81, 1);
            chk_frame(0, 8'h7E, 1);
            chk_frame(0, 8'hD2, 1);
         end
      join
      chk("bp_end", {31'd0, sv[0]}, 32'd0);
      chk("bp_count", {16'd0, tc[0]}, 32'd6);
      fork
         begin
            send(1, 8'hFF);
            send(1, 8'h00);
         end
         begin
            wait_valid(1);
            chk_frame(1, 8'hFF, 1);
            chk("gap1", {31'd0, sv[1]}, 32'd0);
            tick();
            chk("gap2", {31'd0, sv[1]}, 32'd0);
            tick();
            chk_frame(1, 8'h00, 1);
         end
      join
      chk("gap_count", {16'd0, tc[1]}, 32'd2);
      send(2, 8'h01);
      wait_valid(2);
      chk_frame(2, 8'h01, 0);
      chk("lsb_count", {16'd0, tc[2]}, 32'd1);
      send(0, 8'hC3);
      send(0, 8'h5A);
      tick();
      chk("mid_valid", {31'd0, sv[0]}, 32'd1);
      chk("mid_bit2", {31'd0, so[0]}, 32'd0);
      rst = 1'b1;
      tick();
      chk("abort_valid", {31'd0, sv[0]}, 32'd0);
      chk("abort_count", {16'd0, tc[0]}, 32'd0);
      chk("abort_busy", {31'd0, bz[0]}, 32'd0);
      rst = 1'b0;
      #1;
      chk("abort_ready", {31'd0, rdy[0]}, 32'd1);
      quiet = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         quiet = quiet && !sv[0];
      end
      chk("no_remnant", {31'd0, quiet}, 32'd1);
      chk("no_remnant_count", {16'd0, tc[0]}, 32'd0);
      force u0.tx_count_q = 16'hFFFF;
      tick();
      release u0.tx_count_q;
      #1;
      chk("wrap_pre", {16'd0, tc[0]}, 32'h0000FFFF);
      send(0, 8'h55);
      wait_valid(0);
      chk_frame(0, 8'h55, 1);
      chk("wrap_post", {16'd0, tc[0]}, 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
